// File: rtl/audio_sample_feeder.sv
// PCM word FIFO feeding the I2S serializer: pops one word per busy 1->0 edge.
// Build option AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN repeats the last word on underrun instead of emitting 0.
module audio_sample_feeder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LOW_WATER  = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_request,
  input  logic [15:0]           i_wdata,
  output logic                  o_ready,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_low_water,
  input  logic                  i_clear,
  output logic                  o_overflow,
  output logic [15:0]           o_underrun_count,
  input  logic                  i_busy,
  output logic [15:0]           o_sample
);

  localparam int DATA_W = 16;
  localparam int LW     = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         DEPTH   = LW'(1) << DEPTH_LOG2;
  localparam logic [LW-1:0]         ONE_L   = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_P   = DEPTH_LOG2'(1);
  localparam logic                  LOW_RST = (LOW_WATER > 0);

  logic [DATA_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         level, level_nxt;
  logic                  busy_q;
  logic                  pop_p0, wr_ok, rd_ok, underrun, empty, full;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] underrun_word(input logic [DATA_W-1:0] prev);
`ifdef AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN
    return prev;
`else
    return (prev & '0);
`endif
  endfunction

  // Stage 0: word-boundary detect and FIFO accept/pop decisions
  always_comb begin
    pop_p0   = !i_busy && busy_q;
    empty    = (level == '0);
    full     = (level == DEPTH);
    wr_ok    = i_request && (!full || pop_p0);
    rd_ok    = pop_p0 && !empty;
    underrun = pop_p0 && empty;
    level_nxt = level;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level + ONE_L;
      2'b01:   level_nxt = level - ONE_L;
      default: level_nxt = level;
    endcase
  end

  // Stage 1: registered FIFO state, flags and presented sample
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      busy_q           <= 1'b1;
      o_ready          <= 1'b1;
      o_low_water      <= LOW_RST;
      o_overflow       <= 1'b0;
      o_underrun_count <= '0;
      o_sample         <= '0;
    end else begin
      busy_q <= i_busy;
      if (i_clear) begin
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        level            <= '0;
        o_ready          <= 1'b1;
        o_low_water      <= LOW_RST;
        o_overflow       <= 1'b0;
        o_underrun_count <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ONE_P;
        if (rd_ok) rd_ptr <= rd_ptr + ONE_P;
        level       <= level_nxt;
        o_ready     <= (level_nxt != DEPTH);
        o_low_water <= (32'(level_nxt) < LOW_WATER);
        if (i_request && !wr_ok) o_overflow <= 1'b1;
        if (rd_ok) begin
          o_sample <= mem[rd_ptr];
        end else if (underrun) begin
          o_sample         <= underrun_word(o_sample);
          o_underrun_count <= sat_inc(o_underrun_count);
        end
      end
    end
  end

  // Storage is data only; never reset
  always_ff @(posedge i_clock) begin
    if (wr_ok && !i_clear) mem[wr_ptr] <= i_wdata;
  end

  assign o_level = level;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder (DEPTH_LOG2=8, LOW_WATER=64).
module tb_audio_sample_feeder;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_request = 1'b0;
  logic [15:0] i_wdata = '0;
  logic        o_ready;
  logic [8:0]  o_level;
  logic        o_low_water;
  logic        i_clear = 1'b0;
  logic        o_overflow;
  logic [15:0] o_underrun_count;
  logic        i_busy = 1'b1;
  logic [15:0] o_sample;

  int checks = 0;
  int failures = 0;

  audio_sample_feeder #(.DEPTH_LOG2(8), .LOW_WATER(64)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_level(o_level), .o_low_water(o_low_water), .i_clear(i_clear),
    .o_overflow(o_overflow), .o_underrun_count(o_underrun_count), .i_busy(i_busy),
    .o_sample(o_sample)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    i_request = 1'b1;
    i_wdata   = w;
    tick();
    i_request = 1'b0;
  endtask

  task automatic pulse();
    i_busy = 1'b0;
    tick();
    i_busy = 1'b1;
    tick();
  endtask

  task automatic clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  logic [15:0] und_exp;

  initial begin
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    check("rst_level", o_level, 0);
    check("rst_ready", o_ready, 1);
    check("rst_low", o_low_water, 1);
    check("rst_sample", o_sample, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_cnt", o_underrun_count, 0);

    // Underruns on empty FIFO
    repeat (4) pulse();
    check("und_sample", o_sample, 0);
    check("und_cnt", o_underrun_count, 4);
    check("und_low", o_low_water, 1);
    check("und_level", o_level, 0);

    // Basic ordering with one-cycle presentation latency
    push(16'd1); push(16'd2); push(16'd3);
    check("p3_level", o_level, 3);
    for (int k = 1; k <= 3; k++) begin
      i_busy = 1'b0;
      tick();
      check("pop_sample", o_sample, k);
      check("pop_level", o_level, 3 - k);
      i_busy = 1'b1;
      tick();
    end
    check("pop_cnt", o_underrun_count, 4);

    // Fill to full, overflow, drain with wrap
    clear();
    check("clr_cnt", o_underrun_count, 0);
    for (int k = 0; k < 256; k++) push(16'(k));
    check("full_ready", o_ready, 0);
    check("full_ovf_pre", o_overflow, 0);
    push(16'hDEAD);
    check("full_level", o_level, 256);
    check("full_ovf", o_overflow, 1);
    for (int k = 0; k < 256; k++) begin
      pulse();
      check("drain_sample", o_sample, k);
    end
    check("drain_level", o_level, 0);
    check("drain_ready", o_ready, 1);
    check("drain_ovf_sticky", o_overflow, 1);
    check("drain_cnt", o_underrun_count, 0);

    // Long busy-low pulse gives a single pop; simultaneous write+pop
    clear();
    check("clr_ovf", o_overflow, 0);
    push(16'd10); push(16'd11);
    i_busy = 1'b0;
    repeat (10) tick();
    i_busy = 1'b1;
    tick();
    check("long_level", o_level, 1);
    check("long_sample", o_sample, 10);
    for (int k = 12; k <= 15; k++) push(16'(k));
    check("wp_level_pre", o_level, 5);
    i_request = 1'b1; i_wdata = 16'd16; i_busy = 1'b0;
    tick();
    i_request = 1'b0; i_busy = 1'b1;
    check("wp_level", o_level, 5);
    check("wp_sample", o_sample, 11);
    tick();

    // Write and pop on empty: underrun, word stored
    clear();
    push(16'h4321);
    pulse();
    check("we_prev", o_sample, 16'h4321);
    i_request = 1'b1; i_wdata = 16'h0055; i_busy = 1'b0;
    tick();
    i_request = 1'b0; i_busy = 1'b1;
`ifdef AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN
    und_exp = 16'h4321;
`else
    und_exp = 16'h0000;
`endif
    check("we_level", o_level, 1);
    check("we_cnt", o_underrun_count, 1);
    check("we_sample", o_sample, und_exp);
    tick();
    pulse();
    check("we_stored", o_sample, 16'h0055);

    // Low-water threshold crossing
    clear();
    for (int k = 1; k <= 70; k++) begin
      push(16'(100 + k));
      if (k == 63) check("lw_63", o_low_water, 1);
      if (k == 64) check("lw_64", o_low_water, 0);
    end
    check("lw_level", o_level, 70);
    repeat (6) pulse();
    check("lw_pop6", o_low_water, 0);
    pulse();
    check("lw_pop7", o_low_water, 1);
    check("lw_pop7_level", o_level, 63);
    check("lw_sample", o_sample, 107);
    i_request = 1'b1; i_wdata = 16'hBEEF; i_busy = 1'b0; i_clear = 1'b1;
    tick();
    i_request = 1'b0; i_busy = 1'b1; i_clear = 1'b0;
    check("clr_level", o_level, 0);
    check("clr_ovf2", o_overflow, 0);
    check("clr_cnt2", o_underrun_count, 0);
    check("clr_sample_held", o_sample, 107);
    check("clr_low", o_low_water, 1);

    // Underrun after last word 16'h1234
    push(16'h1234);
    pulse();
    check("hold_last", o_sample, 16'h1234);
    pulse();
`ifdef AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN
    und_exp = 16'h1234;
`else
    und_exp = 16'h0000;
`endif
    check("hold_sample", o_sample, und_exp);
    check("hold_cnt", o_underrun_count, 1);

    // Reset mid-stream
    push(16'h7777);
    i_reset = 1'b0;
    #2;
    check("arst_level", o_level, 0);
    check("arst_cnt", o_underrun_count, 0);
    tick();
    i_reset = 1'b1;
    tick();
    pulse();
    check("arst_sample", o_sample, 0);
    check("arst_cnt2", o_underrun_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_sample_feeder.md
Name: audio_sample_feeder

Overview:
- Sample buffer that sits directly upstream of the I2S output stage.
- The CPU/DMA side pushes 16-bit PCM words, interleaved L,R,L,R, into an internal FIFO.
- On each word-boundary strobe from the serializer (its busy output pulses low for one cycle), the block pops the next word and presents it stable on o_sample before the serializer latches it.
- Reports fill level, low-water condition, underruns and overflows for refill interrupts.

Parameters:
- DEPTH_LOG2, 8, FIFO depth = 2^DEPTH_LOG2 words.
- LOW_WATER, 64, o_low_water asserts while level < LOW_WATER.

Ports:
- i_clock  in  1  system clock, same domain as the serializer.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_request  in  1  write strobe, one word per cycle.
- i_wdata  in  16  PCM word to push.
- o_ready  out  1  FIFO not full.
- o_level  out  DEPTH_LOG2+1  current word count.
- o_low_water  out  1  level < LOW_WATER.
- i_clear  in  1  synchronous flush: empties FIFO and clears the flags and counter.
- o_overflow  out  1  sticky; a write was dropped while full.
- o_underrun_count  out  16  saturating count of pops from an empty FIFO.
- i_busy  in  1  busy from serializer; its 1->0 transition marks a word boundary.
- o_sample  out  16  word presented to serializer.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, o_level=0, o_ready=1, o_low_water=1 (when LOW_WATER>0).
  - o_sample=0, o_overflow=0, o_underrun_count=0.
  - Edge register busy_q=1, so no pop occurs on the first cycles after reset.
- Storage: circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth. Level is tracked separately so full and empty are unambiguous.
- Write: i_request && level<depth -> store i_wdata, increment write pointer. i_request while full -> word dropped, o_overflow<=1.
- Pop trigger: pop = (i_busy==0) && (busy_q==1); busy_q <= i_busy every cycle. At most one pop per low pulse, however long the pulse lasts.
- Pop with level>0: o_sample <= head word at the same clock edge, so it is valid from the next cycle. The serializer samples it one cycle after busy low.
- Pop with level==0 (underrun): o_sample <= 16'h0000 and o_underrun_count increments, saturating at 16'hFFFF.
- o_sample is held unchanged between pops.
- Simultaneous write and pop:
  - Non-empty: both take effect, level unchanged.
  - Empty: counts as an underrun; the written word is stored (no bypass) and level becomes 1.
  - Full: the write is accepted because the pop frees a slot; no overflow.
- L/R alignment: the block does not track channel. Software keeps an even word count. One underrun advances the slot without consuming a word, which swaps the channel of all subsequent words. Software recovers with i_clear.
- i_clear has priority over a same-cycle write and pop:
  - Pointers and level go to 0.
  - o_overflow and o_underrun_count clear.
  - o_sample is unchanged.
- o_ready, o_level and o_low_water are registered and reflect the state after the last edge.
- Reset mid-stream: all state is lost; the serializer receives 0 until the next refill.

Optional Feature:
- Macro: AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, o_sample keeps its previous value (last word repeated) instead of 0, to reduce click noise. The counter still increments.
- Undefined: underrun outputs 0 as described above.

Test Plan:
- Reset, then 4 single-cycle i_busy low pulses with an empty FIFO -> o_sample=0, o_underrun_count=4, o_low_water=1, o_level=0.
- Push 1,2,3 then pulse i_busy low 3 times -> o_sample=1,2,3, each valid the cycle after the low cycle, o_level 3->0, no underrun.
- Fill 256 words (DEPTH_LOG2=8), then one more write -> o_ready=0, o_overflow=1, o_level=256. Next pops return words 0..255 in order, and pointers wrap correctly.
- Hold i_busy low 10 cycles -> exactly one pop. A write and a pop in the same cycle with level=5 -> level stays 5.
- Write 70 words with LOW_WATER=64 -> o_low_water deasserts at level 64. 7 pops -> reasserts at 63. i_clear -> level 0, overflow 0, count 0.
- Underrun with AUDIO_FEEDER_HOLD_ON_UNDERRUN_EN defined after last word 16'h1234 -> o_sample stays 16'h1234 and count increments. Without the macro -> 16'h0000.
